// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding and the bubble opcode.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // sll $0,$0,0 doubles as the bubble written into IF/ID
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response channel between the fetch stage (master) and memory (slave).
interface fetch_if #(
  parameter int PC_SIZE = 8
);

  logic               InstrReq;
  logic [PC_SIZE-1:0] InstrAddr;
  logic               InstrReady;
  logic [31:0]        InstrRdata;

  modport master (
    output InstrReq,
    output InstrAddr,
    input  InstrReady,
    input  InstrRdata
  );

  modport slave (
    input  InstrReq,
    input  InstrAddr,
    output InstrReady,
    output InstrRdata
  );

endinterface

// File: rtl/fetch_hold_buffer.sv
// Single-entry holding register that captures an instruction returned while decode is stalled.
module fetch_hold_buffer
  import fetch_pkg::*;
#(
  parameter int PC_SIZE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [31:0]        instr_in,
  input  logic [PC_SIZE-1:0] pcplus1_in,
  output logic [31:0]        instr,
  output logic [PC_SIZE-1:0] pcplus1,
  output logic               valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr   <= NOP_INSTR;
      pcplus1 <= '0;
      valid   <= 1'b0;
    end else if (load) begin
      instr   <= instr_in;
      pcplus1 <= pcplus1_in;
      valid   <= 1'b1;
    end else if (clear) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the memory handshake and drives the IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                 PC_SIZE  = 8,
  parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallD,
  input  logic               PCSrcD,
  input  logic [PC_SIZE-1:0] PCBranchD,
  fetch_if.master            mem,
  output logic [31:0]        InstrD,
  output logic [PC_SIZE-1:0] PCPlus1D,
  output logic               ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        BubbleCnt,
  output logic [31:0]        RedirectCnt
`endif
);

  fetch_state_t       state, state_next;
  logic [PC_SIZE-1:0] pcf, pc_next, pcplus1f;
  logic [PC_SIZE-1:0] addr_q, addr_next;
  logic               redirect, bubble;
  logic               id_we, id_valid;
  logic [31:0]        id_instr;
  logic [PC_SIZE-1:0] id_pcplus1;
  logic               hb_load, hb_clear, hb_valid;
  logic [31:0]        hb_instr;
  logic [PC_SIZE-1:0] hb_pcplus1;

  assign pcplus1f      = pcf + PC_SIZE'(1);
  assign redirect      = PCSrcD && !StallD;
  assign mem.InstrReq  = !rst && (state != HOLD);
  assign mem.InstrAddr = addr_q;

  fetch_hold_buffer #(.PC_SIZE(PC_SIZE)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (hb_load),
    .clear      (hb_clear),
    .instr_in   (mem.InstrRdata),
    .pcplus1_in (pcplus1f),
    .instr      (hb_instr),
    .pcplus1    (hb_pcplus1),
    .valid      (hb_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= REQ;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pc_next    = pcf;
    bubble     = 1'b0;
    id_we      = 1'b0;
    id_instr   = NOP_INSTR;
    id_pcplus1 = PCPlus1D;
    id_valid   = 1'b0;
    hb_load    = 1'b0;
    hb_clear   = 1'b0;
    case (state)
      REQ: begin
        if (redirect) begin
          bubble  = 1'b1;
          pc_next = PCBranchD;
          if (!mem.InstrReady) state_next = DRAIN;
        end else if (mem.InstrReady && StallD) begin
          hb_load    = 1'b1;
          pc_next    = pcplus1f;
          state_next = HOLD;
        end else if (mem.InstrReady) begin
          id_we      = 1'b1;
          id_instr   = mem.InstrRdata;
          id_pcplus1 = pcplus1f;
          id_valid   = 1'b1;
          pc_next    = pcplus1f;
        end else if (!StallD) begin
          bubble = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          hb_clear   = 1'b1;
          bubble     = 1'b1;
          pc_next    = PCBranchD;
          state_next = REQ;
        end else if (!StallD) begin
          hb_clear   = 1'b1;
          id_we      = 1'b1;
          id_instr   = hb_instr;
          id_pcplus1 = hb_pcplus1;
          id_valid   = hb_valid;
          state_next = REQ;
        end
      end
      DRAIN: begin
        // The stale response must still complete, so only PCF follows redirects here
        if (redirect) pc_next = PCBranchD;
        if (!StallD) bubble = 1'b1;
        if (mem.InstrReady) state_next = REQ;
      end
      default: state_next = REQ;
    endcase
    if (bubble) id_we = 1'b1;
    addr_next = (state_next == DRAIN) ? addr_q : pc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf      <= RESET_PC;
      addr_q   <= RESET_PC;
      InstrD   <= NOP_INSTR;
      PCPlus1D <= '0;
      ValidD   <= 1'b0;
    end else begin
      pcf    <= pc_next;
      addr_q <= addr_next;
      if (id_we) begin
        InstrD   <= id_instr;
        PCPlus1D <= id_pcplus1;
        ValidD   <= id_valid;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BubbleCnt   <= '0;
      RedirectCnt <= '0;
    end else begin
      if (bubble && (BubbleCnt != 32'hFFFF_FFFF))     BubbleCnt   <= BubbleCnt + 32'd1;
      if (redirect && (RedirectCnt != 32'hFFFF_FFFF)) RedirectCnt <= RedirectCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a behavioural model.
// Define FETCH_PERF_CNT_EN to also check the performance counters.
module tb_fetch_stage;

  localparam int PC_SIZE = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               StallD;
  logic               PCSrcD;
  logic [PC_SIZE-1:0] PCBranchD;
  logic [31:0]        InstrD;
  logic [PC_SIZE-1:0] PCPlus1D;
  logic               ValidD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        BubbleCnt;
  logic [31:0]        RedirectCnt;
`endif

  fetch_if #(.PC_SIZE(PC_SIZE)) mem_bus ();

  fetch_stage #(.PC_SIZE(PC_SIZE), .RESET_PC(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .StallD    (StallD),
    .PCSrcD    (PCSrcD),
    .PCBranchD (PCBranchD),
    .mem       (mem_bus),
    .InstrD    (InstrD),
    .PCPlus1D  (PCPlus1D),
    .ValidD    (ValidD)
`ifdef FETCH_PERF_CNT_EN
    ,
    .BubbleCnt   (BubbleCnt),
    .RedirectCnt (RedirectCnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] imem [256];
  int checks   = 0;
  int failures = 0;

  // Reference model: architectural view of the fetch unit (next PC, address on the bus,
  // whether a captured instruction or an abandoned response is outstanding, and IF/ID).
  logic [7:0]  m_pc, m_addr;
  bit          m_holding, m_draining, m_in_reset;
  logic [31:0] m_held_instr;
  logic [7:0]  m_held_pcp1;
  logic [31:0] m_instr;
  logic [7:0]  m_pcp1;
  bit          m_valid;
  int          m_bubbles, m_redirects;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic void resetModel();
    m_pc = 8'h00; m_addr = 8'h00;
    m_holding = 1'b0; m_draining = 1'b0;
    m_instr = 32'h0; m_pcp1 = 8'h00; m_valid = 1'b0;
    m_bubbles = 0; m_redirects = 0;
  endfunction

  function automatic void modelBubble();
    m_instr = 32'h0;
    m_valid = 1'b0;
    m_bubbles++;
  endfunction

  function automatic void modelStep(bit stall, bit pcsrc, logic [7:0] target, bit ready, logic [31:0] rdata);
    bit redirect;
    redirect = pcsrc && !stall;
    if (redirect) m_redirects++;
    if (m_holding) begin
      if (redirect) begin
        modelBubble();
        m_holding = 1'b0; m_pc = target; m_addr = target;
      end else if (!stall) begin
        m_instr = m_held_instr; m_pcp1 = m_held_pcp1; m_valid = 1'b1;
        m_holding = 1'b0; m_addr = m_pc;
      end
    end else if (m_draining) begin
      if (redirect) m_pc = target;
      if (!stall) modelBubble();
      if (ready) begin m_draining = 1'b0; m_addr = m_pc; end
    end else begin
      if (redirect) begin
        modelBubble();
        m_pc = target;
        if (ready) m_addr = m_pc;
        else       m_draining = 1'b1;
      end else if (ready && stall) begin
        m_held_instr = rdata; m_held_pcp1 = m_pc + 8'd1;
        m_pc = m_pc + 8'd1; m_holding = 1'b1; m_addr = m_pc;
      end else if (ready) begin
        m_instr = rdata; m_pcp1 = m_pc + 8'd1; m_valid = 1'b1;
        m_pc = m_pc + 8'd1; m_addr = m_pc;
      end else if (!stall) begin
        modelBubble();
      end
    end
  endfunction

  task automatic checkAll(input string tag);
    bit m_req;
    m_req = !m_holding && !m_in_reset;
    checkOutput({tag, ".req"}, mem_bus.InstrReq, m_req);
    if (m_req) checkOutput({tag, ".addr"}, mem_bus.InstrAddr, m_addr);
    checkOutput({tag, ".instr"}, InstrD, m_instr);
    checkOutput({tag, ".pcp1"}, PCPlus1D, m_pcp1);
    checkOutput({tag, ".valid"}, ValidD, m_valid);
`ifdef FETCH_PERF_CNT_EN
    checkOutput({tag, ".bubcnt"}, BubbleCnt, m_bubbles);
    checkOutput({tag, ".redcnt"}, RedirectCnt, m_redirects);
`endif
  endtask

  // Drive one cycle of inputs (called away from the rising edge), advance the model, check after the edge
  task automatic applyStimulus(input bit stall, input bit pcsrc, input logic [7:0] target,
                               input bit ready, input string tag);
    StallD     = stall;
    PCSrcD     = pcsrc;
    PCBranchD  = target;
    mem_bus.InstrReady = ready;
    mem_bus.InstrRdata = imem[m_addr];
    modelStep(stall, pcsrc, target, ready, imem[m_addr]);
    @(negedge clk);
    checkAll(tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = $urandom | 32'h1;
    rst = 1'b1; StallD = 1'b0; PCSrcD = 1'b0; PCBranchD = 8'h00;
    mem_bus.InstrReady = 1'b0; mem_bus.InstrRdata = 32'h0;
    resetModel();
    m_in_reset = 1'b1;
    repeat (2) @(negedge clk);
    checkAll("reset");
    checkOutput("rst_addr", mem_bus.InstrAddr, 32'h0);
    checkOutput("rst_valid", ValidD, 32'h0);
    rst = 1'b0;
    m_in_reset = 1'b0;
    #1;
    checkOutput("req_after_rst", mem_bus.InstrReq, 32'h1);

    // Zero-wait memory streams one instruction per cycle
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "zw");
      checkOutput("zw_instr", InstrD, imem[k-1]);
      checkOutput("zw_pcp1", PCPlus1D, k);
      checkOutput("zw_valid", ValidD, 32'h1);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "zw");

    // Two wait cycles at address 4
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, "wait");
      checkOutput("wait_addr", mem_bus.InstrAddr, 32'h4);
      checkOutput("wait_bubble", InstrD, 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "wait");
    checkOutput("wait_instr", InstrD, imem[4]);
    checkOutput("wait_pcp1", PCPlus1D, 32'h5);

    // Decode stall while address 7 returns
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "pre_stall");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "pre_stall");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, "stall");
    checkOutput("stall_req", mem_bus.InstrReq, 32'h0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, "stall");
      checkOutput("stall_keep", InstrD, imem[6]);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, "unstall");
    checkOutput("unstall_instr", InstrD, imem[7]);
    checkOutput("unstall_addr", mem_bus.InstrAddr, 32'h8);

    // Redirect to 0x20 while address 9 is outstanding
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "pre_redir");
    applyStimulus(1'b0, 1'b1, 8'h20, 1'b0, "redir");
    checkOutput("redir_addr_hold", mem_bus.InstrAddr, 32'h9);
    checkOutput("redir_bubble", ValidD, 32'h0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, "drain");
    checkOutput("drain_addr", mem_bus.InstrAddr, 32'h9);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "drain");
    checkOutput("drain_drop", InstrD, 32'h0);
    checkOutput("redir_target", mem_bus.InstrAddr, 32'h20);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("redir_cnt", RedirectCnt, 32'h1);
    checkOutput("bubble_cnt", BubbleCnt, 32'd5);
`endif

    // PC wrap from 0xFF
    applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1, "to_ff");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "wrap");
    checkOutput("wrap_pcp1", PCPlus1D, 32'h0);
    checkOutput("wrap_addr", mem_bus.InstrAddr, 32'h0);
    checkOutput("wrap_instr", InstrD, imem[255]);

    // Reset while draining an abandoned request
    applyStimulus(1'b0, 1'b1, 8'h40, 1'b0, "pre_rst");
    #2 rst = 1'b1;
    #1;
    resetModel();
    m_in_reset = 1'b1;
    checkAll("mid_rst");
    checkOutput("mid_rst_addr", mem_bus.InstrAddr, 32'h0);
    StallD = 1'b0; PCSrcD = 1'b0; mem_bus.InstrReady = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_in_reset = 1'b0;
    #1;
    checkOutput("post_rst_req", mem_bus.InstrReq, 32'h1);
    checkOutput("post_rst_addr", mem_bus.InstrAddr, 32'h0);

    // Randomized traffic: stalls, redirects and variable memory latency
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                    8'($urandom), $urandom_range(0, 2) != 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
